// File: rtl/nn_input_loader.sv
// rtl/nn_input_loader.sv - packs shifted/narrowed 16-bit samples into an IN_SIZE x 8-bit feature vector
// Optional macro NN_LOADER_SATURATE_EN: saturating narrow instead of two's-complement wrap.
module nn_input_loader #(
  parameter int IN_SIZE = 40,
  parameter int SHIFT   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [15:0]               s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             frame_start,
  output logic signed [7:0]                vector_out [0:IN_SIZE-1],
  output logic                             vector_valid,
  input  logic                             vector_ack,
  output logic [$clog2(IN_SIZE+1)-1:0]     fill_count
);

  localparam int CW = $clog2(IN_SIZE+1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state, state_next;
  logic                  accept;
  logic                  last;
  logic [CW-1:0]         wr_idx;
  logic signed [15:0]    shifted;
  logic signed [7:0]     narrowed;

  assign s_ready = (state == FILL) && !rst;
  assign accept  = s_valid && s_ready;
  // frame_start redirects the current write to element 0
  assign wr_idx  = frame_start ? '0 : fill_count;
  assign last    = (wr_idx == CW'(IN_SIZE - 1));
  assign shifted = s_data >>> SHIFT;

  always_comb begin
    narrowed = 8'(shifted);
`ifdef NN_LOADER_SATURATE_EN
    if (shifted > 16'sd127)
      narrowed = 8'sh7f;
    else if (shifted < -16'sd128)
      narrowed = 8'sh80;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= FILL;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && last) state_next = HOLD;
      HOLD:    if (vector_ack)     state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count   <= '0;
      vector_valid <= 1'b0;
      for (int i = 0; i < IN_SIZE; i++)
        vector_out[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < IN_SIZE; i++)
              if (wr_idx == CW'(i))
                vector_out[i] <= narrowed;
            fill_count   <= wr_idx + CW'(1);
            vector_valid <= last;
          end else if (frame_start) begin
            fill_count <= '0;
          end
        end
        HOLD: begin
          // old elements stay in place until overwritten by the next fill
          if (vector_ack) begin
            vector_valid <= 1'b0;
            fill_count   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// tb/tb_nn_input_loader.sv - scoreboard bench for nn_input_loader with a queue-based reference model
module tb_nn_input_loader;

  localparam int IN_SIZE = 4;
  localparam int SHIFT   = 4;
  localparam int CW      = $clog2(IN_SIZE+1);
  localparam int VW      = 8*IN_SIZE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [15:0]   s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 frame_start;
  logic signed [7:0]    vector_out [0:IN_SIZE-1];
  logic                 vector_valid;
  logic                 vector_ack;
  logic [CW-1:0]        fill_count;

  always #5 clk = ~clk;

  nn_input_loader #(.IN_SIZE(IN_SIZE), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .frame_start(frame_start), .vector_out(vector_out), .vector_valid(vector_valid),
    .vector_ack(vector_ack), .fill_count(fill_count)
  );

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_q[$];
  bit            m_hold;
  int            m_cnt;
  logic [7:0]    m_vec [IN_SIZE];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] narrow(input logic [15:0] d);
    int v;
    v = $signed(d);
    v = v >>> SHIFT;
`ifdef NN_LOADER_SATURATE_EN
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  function automatic logic [VW-1:0] pack_dut();
    logic [VW-1:0] p = '0;
    for (int i = 0; i < IN_SIZE; i++) p = {p[VW-9:0], vector_out[i]};
    return p;
  endfunction

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] p = '0;
    for (int i = 0; i < IN_SIZE; i++) p = {p[VW-9:0], m_vec[i]};
    return p;
  endfunction

  task automatic model_reset();
    m_hold = 0;
    m_cnt  = 0;
    for (int i = 0; i < IN_SIZE; i++) m_vec[i] = 8'h00;
  endtask

  task automatic model_edge(input bit sv, input logic [15:0] d, input bit fs, input bit ack);
    int idx;
    if (!m_hold) begin
      if (sv) begin
        idx = fs ? 0 : m_cnt;
        m_vec[idx] = narrow(d);
        m_cnt = idx + 1;
        if (m_cnt == IN_SIZE) begin
          m_hold = 1;
          exp_q.push_back(pack_model());
        end
      end else if (fs) begin
        m_cnt = 0;
      end
    end else if (ack) begin
      m_hold = 0;
      m_cnt  = 0;
    end
  endtask

  task automatic step(input bit sv, input logic [15:0] d, input bit fs, input bit ack);
    s_valid = sv; s_data = d; frame_start = fs; vector_ack = ack;
    @(posedge clk);
    model_edge(sv, d, fs, ack);
    @(negedge clk);
    chk("fill_count", 64'(fill_count), 64'(m_cnt));
    chk("vector_valid", 64'(vector_valid), 64'(m_hold));
    chk("s_ready", 64'(s_ready), 64'(!m_hold));
    chk("vector_out", 64'(pack_dut()), 64'(pack_model()));
  endtask

  // Scoreboard monitor: one expected vector per rising edge of vector_valid
  bit prev_vv = 0;
  always @(negedge clk) begin
    if (!rst && vector_valid && !prev_vv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: vector_valid with no expected vector, got %0h", pack_dut());
      end else begin
        chk("sb_vector", 64'(pack_dut()), 64'(exp_q.pop_front()));
      end
    end
    prev_vv = vector_valid;
  end

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(vector_valid), 64'd0);
    chk("arst_count", 64'(fill_count), 64'd0);
    chk("arst_vector", 64'(pack_dut()), 64'd0);
    chk("arst_ready", 64'(s_ready), 64'd0);
    model_reset();
    s_valid = 1'b1; s_data = 16'h0300;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_ready", 64'(s_ready), 64'd0);
    chk("rst_hold_count", 64'(fill_count), 64'd0);
    rst = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; frame_start = 1'b0; vector_ack = 1'b0;
    model_reset();
    #3;
    chk("reset_ready", 64'(s_ready), 64'd0);
    chk("reset_valid", 64'(vector_valid), 64'd0);
    chk("reset_count", 64'(fill_count), 64'd0);
    chk("reset_vector", 64'(pack_dut()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1, 16'h0123, 0, 0);
    step(1, 16'hFFF0, 0, 0);
    step(1, 16'h0040, 0, 0);
    step(1, 16'h0000, 0, 0);
    chk("basic_vector", 64'(pack_dut()), 64'h12FF0400);
    chk("basic_valid", 64'(vector_valid), 64'd1);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 1);

    step(1, 16'h7FFF, 0, 0);
    step(1, 16'h8000, 0, 0);
    step(1, 16'h0000, 0, 0);
    step(1, 16'h0000, 0, 0);
`ifdef NN_LOADER_SATURATE_EN
    chk("narrow_extremes", 64'(pack_dut()), 64'h7F800000);
`else
    chk("narrow_extremes", 64'(pack_dut()), 64'hFF000000);
`endif

    for (int i = 0; i < 5; i++) step(1, 16'h0555, 0, 0);
    step(1, 16'h0555, 0, 1);
    step(1, 16'h0555, 0, 0);
    chk("hold_stall_idx0", 64'(vector_out[0]), 64'h55);
    chk("hold_stall_count", 64'(fill_count), 64'd1);

    step(0, 16'h0000, 1, 0);
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h0070, 1, 0);
    chk("restart_idx0", 64'(vector_out[0]), 64'h07);
    chk("restart_count", 64'(fill_count), 64'd1);
    step(1, 16'h0A00, 0, 0);
    step(1, 16'h0B00, 0, 0);
    chk("restart_not_valid", 64'(vector_valid), 64'd0);
    step(1, 16'h0C00, 0, 0);
    chk("restart_valid", 64'(vector_valid), 64'd1);

    async_reset();
    step(1, 16'h0100, 0, 0);
    chk("first_accept", 64'(fill_count), 64'd1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    step(0, 16'h0000, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_input_loader.md
NN_INPUT_LOADER -- requirements
Module: nn_input_loader

Interface
REQ-001 Parameter IN_SIZE, default 40: number of 8-bit feature elements per vector.
REQ-002 Parameter SHIFT, default 4: arithmetic right-shift applied to each 16-bit sample before narrowing to 8 bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  16 signed  incoming feature sample.
REQ-006 s_valid  input  1  s_data valid this cycle.
REQ-007 s_ready  output  1  loader can accept a sample this cycle.
REQ-008 frame_start  input  1  synchronous restart of vector fill at element 0.
REQ-009 vector_out  output  IN_SIZE x 8 signed, indexed [0:IN_SIZE-1]  assembled feature vector driven to the network input.
REQ-010 vector_valid  output  1  vector_out complete and stable.
REQ-011 vector_ack  input  1  consumer has taken vector_out.
REQ-012 fill_count  output  $clog2(IN_SIZE+1)  number of elements written in the current fill.

Function
REQ-013 The block SHALL have two states: FILL and HOLD.
REQ-014 s_ready SHALL be 1 in FILL and 0 in HOLD, and SHALL be 0 while rst is high.
REQ-015 A sample SHALL be accepted on a rising edge where s_valid and s_ready are both 1.
REQ-016 An accepted sample SHALL be written to vector_out[fill_count], and fill_count SHALL then increment by 1.
REQ-017 Each written element SHALL equal narrow(s_data >>> SHIFT), using an arithmetic (sign-preserving) shift.
REQ-018 When the accepted sample lands at index IN_SIZE-1:
  - the state SHALL become HOLD;
  - vector_valid SHALL assert on the next cycle (latency of one clock from the last accept);
  - fill_count SHALL read IN_SIZE.
REQ-019 In HOLD, vector_out and vector_valid SHALL remain stable until vector_ack is sampled high.
REQ-020 vector_ack sampled high in HOLD SHALL cause all of the following on the next cycle:
  - vector_valid 0;
  - fill_count 0;
  - state FILL.
  vector_out SHALL retain its old contents until each element is overwritten.
REQ-021 vector_ack SHALL be ignored in FILL.
REQ-022 frame_start in FILL without an accept SHALL set fill_count to 0.
REQ-023 frame_start and an accept in the same FILL cycle SHALL write the sample to index 0 and set fill_count to 1.
REQ-024 frame_start SHALL be ignored in HOLD.
REQ-025 s_valid while s_ready is 0 SHALL have no effect; the sample is not consumed.
REQ-026 fill_count SHALL never exceed IN_SIZE.
REQ-027 There SHALL be no wrap-around write past index IN_SIZE-1.

Reset
REQ-028 While rst is high, and immediately on its assertion, the block SHALL hold the following values:
  - state FILL;
  - fill_count 0;
  - vector_valid 0;
  - every vector_out element 0;
  - s_ready 0.
REQ-029 Reset asserted in HOLD or mid-fill SHALL discard the partial or complete vector with no vector_valid pulse.
REQ-030 The first accept SHALL be possible on the first rising edge with rst low.

Configuration
REQ-031 The block SHALL support macro NN_LOADER_SATURATE_EN.
REQ-032 With NN_LOADER_SATURATE_EN defined, narrow() SHALL saturate:
  - results above 127 become 127;
  - results below -128 become -128.
REQ-033 With NN_LOADER_SATURATE_EN undefined, narrow() SHALL keep the low 8 bits of the shifted value (two's-complement wrap).

Verification
REQ-034 Scenario: IN_SIZE=4, SHIFT=4, samples 0x0123, 0xFFF0, 0x0040, 0x0000 -> vector_out {0x12, 0xFF, 0x04, 0x00}, vector_valid high one cycle after the 4th accept, s_ready 0.
REQ-035 Scenario: sample 0x7FFF then 0x8000 (SHIFT=4) -> with NN_LOADER_SATURATE_EN: 0x7F, 0x80; without: 0xFF, 0x00.
REQ-036 Scenario: in HOLD, hold s_valid high with 0x0555 for 5 cycles, then pulse vector_ack -> vector_out unchanged in HOLD; vector_valid 0 and fill_count 0 next cycle; the 0x0555 sample is accepted to index 0 the cycle after that.
REQ-037 Scenario: fill 2 samples, then frame_start with s_valid and sample 0x0070 -> vector_out[0]=0x07, fill_count=1; vector_valid only after 3 further accepts.
REQ-038 Scenario: assert rst asynchronously (between edges) in HOLD -> vector_valid, fill_count and all vector_out elements 0 without waiting for a clock edge; s_ready 0 until rst deasserts.
